mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 5: memory access length in cycles, legal range 1..15.
REQ-002 Parameter STARVE_MAX, default 4: consecutive CPU-over-DMA wins before DMA is forced, legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  datapath memory request (MIO_EN); held until cpu_r.
REQ-006 cpu_we  in  1  1=write, 0=read (R_W).
REQ-007 cpu_addr  in  16  datapath address (MAR).
REQ-008 cpu_wdata  in  16  datapath write data (MDR).
REQ-009 cpu_rdata  out  16  read data to MDR.
REQ-010 cpu_r  out  1  one-cycle ready pulse to control (R).
REQ-011 dma_req / dma_we / dma_addr[15:0] / dma_wdata[15:0]  in  DMA port, same semantics as CPU port.
REQ-012 dma_rdata  out  16  read data to DMA.
REQ-013 dma_ack  out  1  one-cycle completion pulse to DMA.
REQ-014 mem_en / mem_we  out  1 each  memory enable / write strobe.
REQ-015 mem_addr / mem_wdata  out  16 each  memory address / write data.
REQ-016 mem_rdata  in  16  memory read data, valid on the last access cycle.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-019 IDLE: if any request is high at a rising edge, latch the winner's id, we, addr, wdata, load the cycle counter with MEM_LAT-1, and go to ACCESS; otherwise stay in IDLE.
REQ-020 Arbitration: CPU wins by default; DMA wins when cpu_req is low, or when both request and starve_cnt == STARVE_MAX.
REQ-021 starve_cnt (4 bits): +1 when CPU wins while dma_req is high; cleared when DMA wins; saturates at STARVE_MAX.
REQ-022 ACCESS: mem_en=1, mem_addr and mem_wdata driven from the latched values, mem_we equals the latched we; counter decrements each cycle; at counter==0 capture mem_rdata if the access is a read, then go to DONE.
REQ-023 DONE: exactly one cycle; pulse cpu_r or dma_ack according to the latched id, mem_en=0, then return to IDLE.
REQ-024 Latency: request first seen high at edge n gives ACCESS during cycles n+1..n+MEM_LAT and the ack pulse in cycle n+MEM_LAT+1.
REQ-025 cpu_rdata updates only on completion of a CPU read; dma_rdata only on completion of a DMA read; writes leave both unchanged.
REQ-026 Requests are sampled only in IDLE; req or data changes during ACCESS/DONE are ignored, and the latched values govern the access.
REQ-027 A requester that still holds req in the IDLE cycle after its ack is granted a new access; the requester drops req on the ack edge.
REQ-028 Outside ACCESS: mem_en=0, mem_we=0, mem_addr and mem_wdata hold their last values.
REQ-029 The loser of a simultaneous request stays pending; it is granted in the next IDLE cycle if still requesting.

Reset
REQ-030 reset low immediately forces IDLE with all outputs 0, starve_cnt=0, counter=0, and latched id/we/addr/wdata=0.
REQ-031 Reset during ACCESS or DONE abandons the access with no ack pulse; the memory write strobe drops asynchronously.
REQ-032 The first grant can occur at the first rising edge after reset deasserts.

Verification (MEM_LAT=5, STARVE_MAX=4)
REQ-033 CPU read addr 3000h, mem_rdata=1234h -> mem_en high 5 cycles, cpu_r pulses in cycle 6 after request, cpu_rdata=1234h, dma_ack stays 0.
REQ-034 CPU and DMA request together with starve_cnt=0 -> CPU served first, DMA granted in the IDLE cycle after cpu_r, starve_cnt returns to 0.
REQ-035 DMA held high while CPU issues 5 back-to-back requests -> CPU wins grants 1-4, the 5th decision goes to DMA, then CPU is served.
REQ-036 DMA write addr FE06h data 0041h -> mem_we high exactly 5 cycles with mem_addr=FE06h and mem_wdata=0041h, dma_ack pulses, cpu_rdata and dma_rdata unchanged.
REQ-037 reset asserted in the 3rd ACCESS cycle -> mem_en and busy go low immediately, no ack; after release, a pending cpu_req gets a fresh full 5-cycle access.
REQ-038 cpu_addr changes from 3000h to 4000h during ACCESS -> mem_addr stays 3000h until DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) memory arbiter with fixed-length accesses.
// The CPU has priority; a starvation counter forces a DMA grant after STARVE_MAX consecutive CPU wins.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_r,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAT_M1     = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            id_q, id_d;
    logic            we_q, we_d;
    logic [DW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
    logic            cpu_r_q, cpu_r_d;
    logic            dma_ack_q, dma_ack_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic            busy_q, busy_d;
    logic            dma_win;

    // DMA takes the grant when the CPU is quiet or has starved it long enough
    assign dma_win = dma_req && (!cpu_req || (starve_q == STARVE_LIM));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_r_q     <= 1'b0;
            dma_ack_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            id_q        <= id_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_r_q     <= cpu_r_d;
            dma_ack_q   <= dma_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        id_d        = id_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    id_d    = dma_win;
                    we_d    = dma_win ? dma_we    : cpu_we;
                    addr_d  = dma_win ? dma_addr  : cpu_addr;
                    wdata_d = dma_win ? dma_wdata : cpu_wdata;
                    cnt_d   = LAT_M1;
                    state_d = ACCESS;
                    if (dma_win) begin
                        starve_d = '0;
                    end else if (dma_req && (starve_q < STARVE_LIM)) begin
                        starve_d = starve_q + CW'(1);
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (id_q) dma_rdata_d = mem_rdata;
                        else      cpu_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered strobes are decoded from the state being entered
        mem_en_d  = (state_d == ACCESS);
        mem_we_d  = (state_d == ACCESS) && we_d;
        cpu_r_d   = (state_d == DONE) && !id_d;
        dma_ack_d = (state_d == DONE) && id_d;
        busy_d    = (state_d != IDLE);
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_r     = cpu_r_q;
    assign dma_ack   = dma_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule
